ps2_player_input: RTL and testbench
===================================

Name: ps2_player_input

Overview:
- Receives PS/2 keyboard frames and decodes scan codes into held-key state vectors for both players.
- Its outputs feed the game's player controls: move[3:0] and shoot for player 1 and player 2.
- Sits on the input side of the game. It is the producer of the control signals that the player and FSM blocks consume.
- Runs on the pixel clock domain.

Parameters:
- FILTER_LEN, 4: number of consecutive identical synchronized samples required before a ps2_clk level change is accepted.
- TIMEOUT_CYCLES, 25000: idle clk_i cycles allowed between PS/2 falling edges mid-frame before the frame is aborted (1 ms at 25 MHz).

Ports:
- clk_i  input  1  system/pixel clock.
- reset_i  input  1  asynchronous, active-high reset.
- ps2_clk_i  input  1  raw PS/2 clock, asynchronous.
- ps2_data_i  input  1  raw PS/2 data, asynchronous.
- player_1_move_o  output  4  held keys: [3]=left A(1C), [2]=right D(23), [1]=up W(1D), [0]=down S(1B).
- player_2_move_o  output  4  held keys: [3]=E0 6B, [2]=E0 74, [1]=E0 75, [0]=E0 72 (arrow keys).
- player_1_shoot_o  output  1  Space (29) held.
- player_2_shoot_o  output  1  Enter (5A, with or without E0) held.
- scan_valid_o  output  1  one-cycle pulse per good byte.
- scan_code_o  output  8  last good byte; holds its value between pulses.
- frame_error_o  output  1  one-cycle pulse on parity, stop-bit or timeout error.

Behaviour:
- Reset:
  - All outputs go to 0.
  - Receiver goes to IDLE. Prefix flags ext and brk are cleared.
  - Sync and filter registers are set to 1 (line idle).
- Reset mid-frame discards the partial frame. After release, the first accepted falling edge is treated as a start bit.
- Input conditioning:
  - Both inputs pass through a 2-flop synchronizer.
  - ps2_clk is filtered by FILTER_LEN.
  - A falling edge event is a filtered transition from 1 to 0. Data is sampled from the synchronized ps2_data on that event.
- Receiver FSM (transitions only on falling edge events, except timeout):
  - IDLE: if data=0 go to DATA with bit count 0. If data=1, stay in IDLE silently (no error).
  - DATA: shift in LSB first. After the 8th bit go to PARITY.
  - PARITY: capture the bit. Go to STOP.
  - STOP: if data=1 and the parity of 8 data bits plus parity bit is odd, the byte is good. Otherwise pulse frame_error_o. Return to IDLE in both cases.
  - Timeout: outside IDLE, a counter increments every clk_i and clears on each edge event. When it reaches TIMEOUT_CYCLES-1, pulse frame_error_o and go to IDLE.
- Good byte handling, registered on the clock after the stop-bit event:
  - scan_valid_o=1 and scan_code_o=byte, both in the same cycle.
  - Decoder, with updates visible in that same cycle:
    - E0: set ext.
    - F0: set brk.
    - Otherwise look up (ext, code). If mapped, set the key bit to !brk. Then clear ext and brk whether mapped or not.
  - Non-extended 6B/74/75/72 are unmapped; player 2 arrows require E0.
  - Extended 1D/1B/1C/23/29 are unmapped.
- On any frame error, clear ext and brk. Key state is unchanged.
- Typematic repeat (repeated make codes) is idempotent.
- Bits are independent. Opposite directions held together both read 1; arbitration belongs to the consumer.
- Latency:
  - Key outputs change exactly 1 clk_i cycle after the clk_i edge on which the stop-bit event is detected.
  - The stop-bit event is detected 2 + FILTER_LEN cycles after the physical edge.
- Counter widths: timeout counter is $clog2(TIMEOUT_CYCLES) bits; bit counter is 3 bits. Neither wraps in normal operation.

Test Plan:
- Send the W make sequence (1D, parity 1, stop 1) → scan_valid_o pulses once with scan_code_o=8'h1D, then player_1_move_o=4'b0010. Send F0 1D → player_1_move_o=4'b0000, with two scan_valid_o pulses (F0, 1D).
- Send E0 75, then E0 74 → player_2_move_o=4'b0110. Send E0 F0 75 → 4'b0100. Send bare 75 → no change.
- Send 29, then E0 5A → player_1_shoot_o=1 and player_2_shoot_o=1. Send F0 5A → player_2_shoot_o=0 and player_1_shoot_o stays 1.
- Send 1C with a wrong parity bit → frame_error_o pulses once, no scan_valid_o, outputs unchanged. Then send a valid 1C → player_1_move_o[3]=1.
- Stop ps2_clk after 4 data bits for TIMEOUT_CYCLES+10 cycles → frame_error_o pulses once and the FSM is in IDLE. A following full 23 frame is decoded correctly (player_1_move_o[2]=1).
- Send E0, then assert reset_i asynchronously mid-frame → all outputs 0 immediately. After release, send 75 → player_2_move_o stays 0 (ext was cleared by reset); scan_code_o=8'h75.
- Pulse ps2_clk low for FILTER_LEN-1 cycles → no bit is sampled.

Source files
------------

// File: rtl/ps2_player_input.sv
// PS/2 keyboard receiver and scan-code decoder producing held-key vectors
// for two players (WASD/Space and arrows/Enter).
module ps2_player_input #(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 25000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [3:0] player_1_move_o,
    output logic [3:0] player_2_move_o,
    output logic       player_1_shoot_o,
    output logic       player_2_shoot_o,
    output logic       scan_valid_o,
    output logic [7:0] scan_code_o,
    output logic       frame_error_o
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned FL_W = $clog2(FILTER_LEN + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    logic            clk_s1, clk_s2, dat_s1, dat_s2;
    logic            filt_level;
    logic [FL_W-1:0] filt_cnt;
    logic            fall_evt, fall_data;

    rx_state_t       state;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            par;
    logic [TO_W-1:0] to_cnt;
    logic            ext, brk;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            clk_s1     <= 1'b1;
            clk_s2     <= 1'b1;
            dat_s1     <= 1'b1;
            dat_s2     <= 1'b1;
            filt_level <= 1'b1;
            filt_cnt   <= '0;
            fall_evt   <= 1'b0;
            fall_data  <= 1'b1;
        end else begin
            clk_s1    <= ps2_clk_i;
            clk_s2    <= clk_s1;
            dat_s1    <= ps2_data_i;
            dat_s2    <= dat_s1;
            fall_data <= dat_s2;
            // Level flips only after FILTER_LEN consecutive differing samples.
            fall_evt  <= (clk_s2 != filt_level) && (filt_cnt == FL_W'(FILTER_LEN - 1))
                         && filt_level;
            if (clk_s2 == filt_level) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FL_W'(FILTER_LEN - 1)) begin
                filt_level <= clk_s2;
                filt_cnt   <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state            <= IDLE;
            bit_cnt          <= '0;
            shift            <= '0;
            par              <= 1'b0;
            to_cnt           <= '0;
            ext              <= 1'b0;
            brk              <= 1'b0;
            player_1_move_o  <= '0;
            player_2_move_o  <= '0;
            player_1_shoot_o <= 1'b0;
            player_2_shoot_o <= 1'b0;
            scan_valid_o     <= 1'b0;
            scan_code_o      <= '0;
            frame_error_o    <= 1'b0;
        end else begin
            scan_valid_o  <= 1'b0;
            frame_error_o <= 1'b0;
            if (state == IDLE) begin
                to_cnt <= '0;
                if (fall_evt && !fall_data) begin
                    state   <= DATA;
                    bit_cnt <= '0;
                end
            end else if (!fall_evt && to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                frame_error_o <= 1'b1;
                ext           <= 1'b0;
                brk           <= 1'b0;
                state         <= IDLE;
            end else if (!fall_evt) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
                case (state)
                    DATA: begin
                        shift <= {fall_data, shift[7:1]};
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            state   <= PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        par   <= fall_data;
                        state <= STOP;
                    end
                    default: begin
                        state <= IDLE;
                        if (fall_data && (^{shift, par})) begin
                            scan_valid_o <= 1'b1;
                            scan_code_o  <= shift;
                            if (shift == 8'hE0) begin
                                ext <= 1'b1;
                            end else if (shift == 8'hF0) begin
                                brk <= 1'b1;
                            end else begin
                                if (shift == 8'h5A) begin
                                    player_2_shoot_o <= !brk;
                                end else begin
                                    case ({ext, shift})
                                        9'h01C: player_1_move_o[3] <= !brk;
                                        9'h023: player_1_move_o[2] <= !brk;
                                        9'h01D: player_1_move_o[1] <= !brk;
                                        9'h01B: player_1_move_o[0] <= !brk;
                                        9'h029: player_1_shoot_o   <= !brk;
                                        9'h16B: player_2_move_o[3] <= !brk;
                                        9'h174: player_2_move_o[2] <= !brk;
                                        9'h175: player_2_move_o[1] <= !brk;
                                        9'h172: player_2_move_o[0] <= !brk;
                                        default: ;
                                    endcase
                                end
                                ext <= 1'b0;
                                brk <= 1'b0;
                            end
                        end else begin
                            frame_error_o <= 1'b1;
                            ext           <= 1'b0;
                            brk           <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_player_input.sv
// Scoreboard bench for ps2_player_input: frames are bit-banged, expected
// byte/error events are queued on send and popped when the DUT pulses.
module tb_ps2_player_input;

    localparam int unsigned FILTER_LEN     = 4;
    localparam int unsigned TIMEOUT_CYCLES = 25000;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic [3:0] player_1_move_o, player_2_move_o;
    logic       player_1_shoot_o, player_2_shoot_o;
    logic       scan_valid_o, frame_error_o;
    logic [7:0] scan_code_o;

    int unsigned err_cnt = 0;
    int unsigned chk_cnt = 0;
    logic [8:0]  sb[$];

    ps2_player_input #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .ps2_clk_i       (ps2_clk_i),
        .ps2_data_i      (ps2_data_i),
        .player_1_move_o (player_1_move_o),
        .player_2_move_o (player_2_move_o),
        .player_1_shoot_o(player_1_shoot_o),
        .player_2_shoot_o(player_2_shoot_o),
        .scan_valid_o    (scan_valid_o),
        .scan_code_o     (scan_code_o),
        .frame_error_o   (frame_error_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every output pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset_i && (scan_valid_o || frame_error_o)) begin
            if (sb.size() == 0) begin
                check_val("sb_unexpected", {22'd0, frame_error_o, scan_valid_o, scan_code_o}, 32'd0);
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                check_val(e[8] ? "sb_error" : "sb_code",
                          {22'd0, frame_error_o, scan_valid_o, frame_error_o ? 8'h00 : scan_code_o},
                          {22'd0, e[8], ~e[8], e[8] ? 8'h00 : e[7:0]});
            end
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data_i = b;
        tick(8);
        ps2_clk_i = 1'b0;
        tick(15);
        ps2_clk_i = 1'b1;
        tick(7);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        if (bad_par) sb.push_back({1'b1, 8'h00});
        else         sb.push_back({1'b0, b});
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(1'b1);
        ps2_data_i = 1'b1;
        tick(40);
    endtask

    task automatic send_partial(input logic [7:0] b, input int unsigned n);
        ps2_bit(1'b0);
        for (int i = 0; i < n; i++) ps2_bit(b[i]);
        ps2_data_i = 1'b1;
    endtask

    initial begin
        reset_i    = 1'b1;
        ps2_clk_i  = 1'b1;
        ps2_data_i = 1'b1;
        tick(5);
        check_val("rst_p1_move", {28'd0, player_1_move_o}, 32'h0);
        check_val("rst_p2_move", {28'd0, player_2_move_o}, 32'h0);
        check_val("rst_shoot", {30'd0, player_1_shoot_o, player_2_shoot_o}, 32'h0);
        check_val("rst_scan", {23'd0, scan_valid_o, scan_code_o}, 32'h0);
        check_val("rst_ferr", {31'd0, frame_error_o}, 32'h0);
        reset_i = 1'b0;
        tick(10);

        send_byte(8'h1D, 1'b0);
        check_val("w_make", {28'd0, player_1_move_o}, 32'b0010);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1D, 1'b0);
        check_val("w_break", {28'd0, player_1_move_o}, 32'b0000);

        send_byte(8'hE0, 1'b0);
        send_byte(8'h75, 1'b0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'h74, 1'b0);
        check_val("arrows_make", {28'd0, player_2_move_o}, 32'b0110);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        check_val("up_break", {28'd0, player_2_move_o}, 32'b0100);
        send_byte(8'h75, 1'b0);
        check_val("bare_75", {28'd0, player_2_move_o}, 32'b0100);
        check_val("bare_75_p1", {28'd0, player_1_move_o}, 32'b0000);

        send_byte(8'h29, 1'b0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'h5A, 1'b0);
        check_val("shoot_both", {30'd0, player_1_shoot_o, player_2_shoot_o}, 32'b11);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h5A, 1'b0);
        check_val("enter_break", {30'd0, player_1_shoot_o, player_2_shoot_o}, 32'b10);

        send_byte(8'h1C, 1'b1);
        check_val("bad_par_keys", {28'd0, player_1_move_o}, 32'b0000);
        check_val("bad_par_code", {24'd0, scan_code_o}, 32'h5A);
        send_byte(8'h1C, 1'b0);
        check_val("a_make", {28'd0, player_1_move_o}, 32'b1000);

        sb.push_back({1'b1, 8'h00});
        send_partial(8'h23, 4);
        tick(TIMEOUT_CYCLES + 10);
        check_val("timeout_drain", sb.size(), 0);
        check_val("timeout_state", {30'd0, dut.state}, 32'd0);
        send_byte(8'h23, 1'b0);
        check_val("d_after_to", {28'd0, player_1_move_o}, 32'b1100);

        // Glitch with data low: a sampled start bit would misalign the next frame.
        ps2_data_i = 1'b0;
        tick(2);
        ps2_clk_i = 1'b0;
        tick(FILTER_LEN - 1);
        ps2_clk_i = 1'b1;
        tick(2);
        ps2_data_i = 1'b1;
        tick(40);
        check_val("glitch_state", {30'd0, dut.state}, 32'd0);
        send_byte(8'h1B, 1'b0);
        check_val("s_after_glitch", {28'd0, player_1_move_o}, 32'b1101);

        send_byte(8'hE0, 1'b0);
        send_partial(8'h1D, 3);
        tick(3);
        #3 reset_i = 1'b1;
        #1;
        check_val("arst_p1", {28'd0, player_1_move_o}, 32'h0);
        check_val("arst_p2", {28'd0, player_2_move_o}, 32'h0);
        check_val("arst_shoot", {30'd0, player_1_shoot_o, player_2_shoot_o}, 32'h0);
        check_val("arst_code", {24'd0, scan_code_o}, 32'h0);
        tick(5);
        reset_i = 1'b0;
        tick(10);
        send_byte(8'h75, 1'b0);
        check_val("post_rst_p2", {28'd0, player_2_move_o}, 32'h0);
        check_val("post_rst_code", {24'd0, scan_code_o}, 32'h75);

        tick(20);
        check_val("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
